// File: rtl/ucode_dispatch.sv
// ucode_dispatch: round-robin launcher for the shared microcode sequencer.
// Picks one requester, captures its start address and loop bounds, and pulses
// start_pos. It holds the bounds while the program runs, then returns a
// one-cycle rsp_done to that requester.
// Optional feature macro: UCODE_DISPATCH_WDT_EN. When it is defined, a run
// watchdog aborts a program that never signals done.
module ucode_dispatch #(
  parameter int NUM_REQ          = 4,
  parameter int UINST_ADDR_WIDTH = 8,
  parameter int LOOP_W           = 11,
  parameter int WDT_CYCLES       = 4096
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    req_valid,
  input  logic [NUM_REQ*UINST_ADDR_WIDTH-1:0]   req_upc,
  input  logic [NUM_REQ*LOOP_W-1:0]             req_loop0,
  input  logic [NUM_REQ*LOOP_W-1:0]             req_loop1,
  input  logic [NUM_REQ*LOOP_W-1:0]             req_loop2,
  output logic [NUM_REQ-1:0]                    req_ready,
  output logic [NUM_REQ-1:0]                    rsp_done,
  output logic                                  rsp_err,
  output logic                                  start_pos,
  output logic [UINST_ADDR_WIDTH-1:0]           upc_start,
  output logic [LOOP_W-1:0]                     loop_0,
  output logic [LOOP_W-1:0]                     loop_1,
  output logic [LOOP_W-1:0]                     loop_2,
  input  logic                                  done,
  output logic                                  abort,
  output logic                                  busy,
  output logic [2:0]                            grant_id
);

  localparam int PTR_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LAUNCH = 2'd1;
  localparam logic [1:0] RUN    = 2'd2;
  localparam logic [1:0] CMPL   = 2'd3;

  // Reject unsupported configurations at elaboration time.
  if (NUM_REQ < 2 || NUM_REQ > 8 || WDT_CYCLES < 2) begin : g_param_check
    $error("ucode_dispatch: NUM_REQ must be 2..8 and WDT_CYCLES at least 2");
  end

  logic [1:0]                  state;
  logic [PTR_W-1:0]            ptr;
  logic [PTR_W-1:0]            next_ptr;
  logic                        pick_valid;
  logic [2:0]                  pick_idx;
  logic                        xfer;
  logic [UINST_ADDR_WIDTH-1:0] pick_upc;
  logic [LOOP_W-1:0]           pick_l0;
  logic [LOOP_W-1:0]           pick_l1;
  logic [LOOP_W-1:0]           pick_l2;
  logic [NUM_REQ-1:0]          grant_onehot;
  logic                        wdt_expire;

  // A bound of zero would make the sequencer counter wrap to all ones, so it
  // is raised to one; every other bound passes through untouched.
  function automatic logic [LOOP_W-1:0] fix_bound(input logic [LOOP_W-1:0] b);
    if (b == {LOOP_W{1'b0}}) begin
      fix_bound = {{(LOOP_W-1){1'b0}}, 1'b1};
    end else begin
      fix_bound = b;
    end
  endfunction

  // Round-robin search: first valid requester at or above the pointer, wrapping.
  always_comb begin
    int idx;
    idx        = 0;
    pick_valid = 1'b0;
    pick_idx   = 3'd0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(ptr) + off) % NUM_REQ;
      if (!pick_valid && req_valid[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = 3'(idx);
      end else begin
        pick_valid = pick_valid;
      end
    end
  end

  // One-hot accept is only offered while idle and out of reset.
  always_comb begin
    req_ready = {NUM_REQ{1'b0}};
    if (state == IDLE && !rst && pick_valid) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        req_ready[i] = (pick_idx == 3'(i));
      end
    end else begin
      req_ready = {NUM_REQ{1'b0}};
    end
  end

  assign xfer = |(req_ready & req_valid);
  assign busy = (state != IDLE);

  // Slice out the fields of the requester being picked.
  always_comb begin
    pick_upc = req_upc[int'(pick_idx)*UINST_ADDR_WIDTH +: UINST_ADDR_WIDTH];
    pick_l0  = req_loop0[int'(pick_idx)*LOOP_W +: LOOP_W];
    pick_l1  = req_loop1[int'(pick_idx)*LOOP_W +: LOOP_W];
    pick_l2  = req_loop2[int'(pick_idx)*LOOP_W +: LOOP_W];
  end

  // Completion vector for the current grant and the pointer that follows it.
  always_comb begin
    int nxt;
    nxt          = (int'(grant_id) + 1) % NUM_REQ;
    next_ptr     = PTR_W'(nxt);
    grant_onehot = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_onehot[i] = (grant_id == 3'(i));
    end
  end

`ifdef UCODE_DISPATCH_WDT_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

  logic [WDT_W-1:0] wdt_cnt;

  assign wdt_expire = (state == RUN) && (wdt_cnt == WDT_LAST);

  // Run-length counter: zeroed while launching, counts every RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdt_cnt <= {WDT_W{1'b0}};
    end else if (state == LAUNCH) begin
      wdt_cnt <= {WDT_W{1'b0}};
    end else if (state == RUN && wdt_cnt != WDT_LAST) begin
      wdt_cnt <= wdt_cnt + {{(WDT_W-1){1'b0}}, 1'b1};
    end else begin
      wdt_cnt <= wdt_cnt;
    end
  end

  // Abort and error flag pulse together when the watchdog ends a run; a done
  // in the expiry cycle takes priority and suppresses both.
  always_ff @(posedge clk) begin
    if (rst) begin
      abort   <= 1'b0;
      rsp_err <= 1'b0;
    end else if (wdt_expire && !done) begin
      abort   <= 1'b1;
      rsp_err <= 1'b1;
    end else begin
      abort   <= 1'b0;
      rsp_err <= 1'b0;
    end
  end
`else
  assign wdt_expire = 1'b0;
  assign abort      = 1'b0;
  assign rsp_err    = 1'b0;
`endif

  // Main sequencing: capture on transfer, launch, wait for done, complete.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= {PTR_W{1'b0}};
      grant_id  <= 3'd0;
      upc_start <= {UINST_ADDR_WIDTH{1'b0}};
      loop_0    <= {LOOP_W{1'b0}};
      loop_1    <= {LOOP_W{1'b0}};
      loop_2    <= {LOOP_W{1'b0}};
      start_pos <= 1'b0;
      rsp_done  <= {NUM_REQ{1'b0}};
    end else begin
      start_pos <= 1'b0;
      rsp_done  <= {NUM_REQ{1'b0}};
      case (state)
        IDLE: begin
          if (xfer) begin
            grant_id  <= pick_idx;
            upc_start <= pick_upc;
            loop_0    <= fix_bound(pick_l0);
            loop_1    <= fix_bound(pick_l1);
            loop_2    <= fix_bound(pick_l2);
            start_pos <= 1'b1;
            state     <= LAUNCH;
          end else begin
            state <= IDLE;
          end
        end
        LAUNCH: begin
          // done is deliberately not looked at here.
          state <= RUN;
        end
        RUN: begin
          if (done || wdt_expire) begin
            rsp_done <= grant_onehot;
            state    <= CMPL;
          end else begin
            state <= RUN;
          end
        end
        CMPL: begin
          ptr   <= next_ptr;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
